// File: rtl/genius_sequencer.sv
// genius_sequencer: "Genius"/Simon memory game sequencer driven by decoded IR key strobes.
// The game plays back a growing colour sequence on a one-hot lamp. It then checks the
// player's key presses against that sequence.
// Optional feature: define GENIUS_TIMEOUT_EN to make an idle WAIT_IN lose after
// TIMEOUT_CYCLES cycles; left undefined, WAIT_IN waits forever and no timeout path is built.
module genius_sequencer #(
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       b_blue,
  input  logic       b_yellow,
  input  logic       b_green,
  input  logic       b_red,
  input  logic       b_power,
  input  logic [1:0] color,
  output logic [3:0] led,
  output logic [4:0] level,
  output logic       busy,
  output logic       win,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ADD,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_WAIT_IN,
    S_WIN,
    S_LOSE
  } state_t;

  // Timers count 0..N-1, so the terminal compare value is N-1.
  localparam logic [27:0] L_SHOW_LAST = 28'(SHOW_CYCLES - 1);
  localparam logic [27:0] L_GAP_LAST  = 28'(GAP_CYCLES - 1);
`ifdef GENIUS_TIMEOUT_EN
  localparam logic [27:0] L_TO_LAST   = 28'(TIMEOUT_CYCLES - 1);
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_mem [16];
  logic [4:0]  r_len;
  logic [4:0]  w_len_nxt;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_nxt;
  logic [27:0] r_timer;
  logic        w_tmr_clr;
  logic        w_mem_we;
  logic [3:0]  r_keyled;
  logic [3:0]  w_keyled_nxt;
  logic        r_rdy_prev;
  logic        r_armed;
  logic [3:0]  r_led;
  logic [3:0]  w_led_nxt;
  logic        r_busy;
  logic        r_win;
  logic        r_game_over;

  logic [4:0]  w_btns;
  logic        w_rise;
  logic        w_single;
  logic        w_pwr_evt;
  logic        w_col_evt;
  logic [1:0]  w_key;
  logic [1:0]  w_show_code;

  // Colour code to lamp bit.
  function automatic logic [3:0] f_led(input logic [1:0] code);
    f_led = 4'(4'b0001 << code);
  endfunction

  // True when exactly one strobe is asserted.
  function automatic logic f_onehot5(input logic [4:0] v);
    f_onehot5 = (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  assign w_btns    = {b_power, b_red, b_green, b_yellow, b_blue};
  // r_armed blocks a press when rdy was already high as reset was released.
  assign w_rise    = rdy & ~r_rdy_prev & r_armed;
  assign w_single  = f_onehot5(w_btns);
  assign w_pwr_evt = w_rise & w_single & b_power;
  assign w_col_evt = w_rise & w_single & ~b_power;

  always_comb begin
    w_key = 2'd0;
    if (b_yellow)   w_key = 2'd1;
    else if (b_green) w_key = 2'd2;
    else if (b_red)   w_key = 2'd3;
  end

  // Edge detector history and arming flag for the rdy command window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_prev <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_rdy_prev <= rdy;
      r_armed    <= r_armed | ~rdy;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath update decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_idx_nxt    = r_idx;
    w_keyled_nxt = r_keyled;
    w_mem_we     = 1'b0;
    w_tmr_clr    = 1'b0;
    if (w_pwr_evt) begin
      // Power starts a game from rest states and aborts a game in progress.
      if (r_state == S_IDLE || r_state == S_WIN || r_state == S_LOSE) w_state_nxt = S_GAP;
      else                                                            w_state_nxt = S_IDLE;
      w_len_nxt    = 5'd0;
      w_idx_nxt    = 4'd0;
      w_keyled_nxt = 4'd0;
    end else begin
      case (r_state)
        S_GAP: begin
          if (r_timer == L_GAP_LAST) w_state_nxt = S_ADD;
        end
        S_ADD: begin
          w_mem_we    = 1'b1;
          w_len_nxt   = r_len + 5'd1;
          w_idx_nxt   = 4'd0;
          w_state_nxt = S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (r_timer == L_SHOW_LAST) w_state_nxt = S_SHOW_OFF;
        end
        S_SHOW_OFF: begin
          if (r_timer == L_GAP_LAST) begin
            if ({1'b0, r_idx} + 5'd1 == r_len) begin
              w_idx_nxt    = 4'd0;
              w_keyled_nxt = 4'd0;
              w_state_nxt  = S_WAIT_IN;
            end else begin
              w_idx_nxt   = r_idx + 4'd1;
              w_state_nxt = S_SHOW_ON;
            end
          end
        end
        S_WAIT_IN: begin
          if (w_col_evt) begin
            if (w_key == r_mem[r_idx]) begin
              w_keyled_nxt = f_led(w_key);
              w_tmr_clr    = 1'b1;
              if ({1'b0, r_idx} + 5'd1 == r_len) begin
                w_idx_nxt   = 4'd0;
                w_state_nxt = (r_len == 5'd16) ? S_WIN : S_GAP;
              end else begin
                w_idx_nxt = r_idx + 4'd1;
              end
            end else begin
              w_state_nxt = S_LOSE;
            end
          end
`ifdef GENIUS_TIMEOUT_EN
          else if (r_timer == L_TO_LAST) begin
            w_state_nxt = S_LOSE;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Length, playback index and last-accepted-key lamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len    <= 5'd0;
      r_idx    <= 4'd0;
      r_keyled <= 4'd0;
    end else begin
      r_len    <= w_len_nxt;
      r_idx    <= w_idx_nxt;
      r_keyled <= w_keyled_nxt;
    end
  end

  // Sequence memory; contents are meaningless until written by ADD, so no reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_len[3:0]] <= color;
  end

  // State timer: restarts on every state entry and on each accepted key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= 28'd0;
    end else if (w_state_nxt != r_state || w_tmr_clr) begin
      r_timer <= 28'd0;
    end else if (r_state == S_GAP || r_state == S_SHOW_ON || r_state == S_SHOW_OFF) begin
      r_timer <= r_timer + 28'd1;
    end
`ifdef GENIUS_TIMEOUT_EN
    else if (r_state == S_WAIT_IN) begin
      r_timer <= r_timer + 28'd1;
    end
`endif
  end

  // The first SHOW_ON of a round may read the entry ADD is writing this very cycle.
  assign w_show_code = (w_mem_we && (w_idx_nxt == r_len[3:0])) ? color : r_mem[w_idx_nxt];

  // Lamp value for the state being entered.
  always_comb begin
    w_led_nxt = 4'd0;
    case (w_state_nxt)
      S_SHOW_ON: w_led_nxt = f_led(w_show_code);
      S_WAIT_IN: w_led_nxt = w_keyled_nxt;
      S_WIN:     w_led_nxt = 4'b1111;
      default:   w_led_nxt = 4'd0;
    endcase
  end

  // Registered outputs, aligned with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led       <= 4'd0;
      r_busy      <= 1'b0;
      r_win       <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_led       <= w_led_nxt;
      r_busy      <= (w_state_nxt == S_GAP) || (w_state_nxt == S_ADD) ||
                     (w_state_nxt == S_SHOW_ON) || (w_state_nxt == S_SHOW_OFF);
      r_win       <= (w_state_nxt == S_WIN);
      r_game_over <= (w_state_nxt == S_LOSE);
    end
  end

  assign led       = r_led;
  assign level     = r_len;
  assign busy      = r_busy;
  assign win       = r_win;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_genius_sequencer.sv
// Directed bench for genius_sequencer with short timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_genius_sequencer;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic       b_blue, b_yellow, b_green, b_red, b_power;
  logic [1:0] color;
  logic [3:0] led;
  logic [4:0] level;
  logic       busy, win, game_over;

  int n_checks;
  int n_errors;
  logic [3:0] shown [32];

  // Hand-picked colour sequence for the full 16-round game.
  int seq16 [16] = '{2, 0, 3, 1, 1, 2, 3, 0, 0, 3, 2, 2, 1, 0, 3, 1};

  localparam logic [4:0] K_BLUE   = 5'b00001;
  localparam logic [4:0] K_YELLOW = 5'b00010;
  localparam logic [4:0] K_GREEN  = 5'b00100;
  localparam logic [4:0] K_RED    = 5'b01000;
  localparam logic [4:0] K_POWER  = 5'b10000;

  genius_sequencer #(
    .SHOW_CYCLES(4),
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .b_blue(b_blue), .b_yellow(b_yellow), .b_green(b_green), .b_red(b_red), .b_power(b_power),
    .color(color), .led(led), .level(level), .busy(busy), .win(win), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_btns(input logic [4:0] b);
    {b_power, b_red, b_green, b_yellow, b_blue} = b;
  endtask

  // One-cycle press; returns on the falling edge after the event was clocked in.
  task automatic press(input logic [4:0] b);
    set_btns(b);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    set_btns(5'd0);
  endtask

  // Observe a busy phase until busy drops, recording each distinct lit colour.
  task automatic run_playback(output int busy_cnt, output int on_cnt, output int n_shows);
    logic [3:0] prev;
    int n;
    busy_cnt = 0; on_cnt = 0; n_shows = 0; prev = 4'd0; n = 0;
    while (busy === 1'b1 && n < 300) begin
      busy_cnt++;
      if (led != 4'd0) begin
        on_cnt++;
        if (prev == 4'd0 && n_shows < 32) begin
          shown[n_shows] = led;
          n_shows++;
        end
      end
      prev = led;
      n++;
      @(negedge clk);
    end
    if (n >= 300) check("playback_bound", 32'(n), 32'd0);
  endtask

  initial begin
    int bc, oc, ns, n;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; rdy = 1'b0; set_btns(5'd0); color = 2'd0;
    repeat (2) tick();

    // Reset state
    check("rst_led", 32'(led), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_win", 32'(win), 32'd0);
    check("rst_go", 32'(game_over), 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_busy", 32'(busy), 32'd0);

    // First round: green, 2+1+4+2 busy cycles
    color = 2'd2;
    press(K_POWER);
    check("gap_level", 32'(level), 32'd0);
    check("gap_led", 32'(led), 32'd0);
    run_playback(bc, oc, ns);
    check("r1_busy_cyc", 32'(bc), 32'd9);
    check("r1_on_cyc", 32'(oc), 32'd4);
    check("r1_shows", 32'(ns), 32'd1);
    check("r1_colour", 32'(shown[0]), 32'(4'b0100));
    check("r1_level", 32'(level), 32'd1);
    check("r1_wait_led", 32'(led), 32'd0);

    // Round 2 is green, blue; then a wrong first key loses
    color = 2'd0;
    press(K_GREEN);
    run_playback(bc, oc, ns);
    check("r2_busy_cyc", 32'(bc), 32'd15);
    check("r2_shows", 32'(ns), 32'd2);
    check("r2_col0", 32'(shown[0]), 32'(4'b0100));
    check("r2_col1", 32'(shown[1]), 32'(4'b0001));
    check("r2_level", 32'(level), 32'd2);
    press(K_BLUE);
    check("lose_go", 32'(game_over), 32'd1);
    check("lose_led", 32'(led), 32'd0);
    check("lose_busy", 32'(busy), 32'd0);
    check("lose_win", 32'(win), 32'd0);

    // Restart from LOSE; red, red; held press and dual-button press
    tick();
    color = 2'd3;
    press(K_POWER);
    check("restart_go", 32'(game_over), 32'd0);
    check("restart_level", 32'(level), 32'd0);
    run_playback(bc, oc, ns);
    check("red_r1", 32'(shown[0]), 32'(4'b1000));
    press(K_RED);
    run_playback(bc, oc, ns);
    check("red_r2_shows", 32'(ns), 32'd2);
    set_btns(K_RED);
    rdy = 1'b1;
    repeat (4) tick();
    rdy = 1'b0;
    set_btns(5'd0);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_keyled", 32'(led), 32'(4'b1000));
    tick();
    press(K_RED | K_BLUE);
    tick();
    check("dual_busy", 32'(busy), 32'd0);
    check("dual_go", 32'(game_over), 32'd0);
    check("dual_led", 32'(led), 32'(4'b1000));
    press(K_RED);
    check("red_r2_done", 32'(busy), 32'd1);

    // Power during GAP aborts to IDLE
    tick();
    press(K_POWER);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_level", 32'(level), 32'd0);
    check("abort_led", 32'(led), 32'd0);
    check("abort_go", 32'(game_over), 32'd0);
    repeat (4) tick();
    check("abort_idle", 32'(busy), 32'd0);

    // Full 16-round game
    color = 2'(seq16[0]);
    press(K_POWER);
    for (int r = 1; r <= 16; r++) begin
      run_playback(bc, oc, ns);
      check("g_level", 32'(level), 32'(r));
      check("g_shows", 32'(ns), 32'(r));
      check("g_busy_cyc", 32'(bc), 32'(3 + 6 * r));
      for (int i = 0; i < r; i++) check("g_colour", 32'(shown[i]), 32'(oh(seq16[i])));
      if (r < 16) color = 2'(seq16[r]);
      for (int i = 0; i < r; i++) begin
        press(5'(1 << seq16[i]));
        if (i < r - 1) begin
          check("g_keyled", 32'(led), 32'(oh(seq16[i])));
          tick();
        end
      end
    end
    check("win_win", 32'(win), 32'd1);
    check("win_led", 32'(led), 32'(4'b1111));
    check("win_level", 32'(level), 32'd16);
    check("win_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("win_hold", 32'(win), 32'd1);
    color = 2'd1;
    press(K_POWER);
    check("rewin_level", 32'(level), 32'd0);
    check("rewin_win", 32'(win), 32'd0);
    check("rewin_busy", 32'(busy), 32'd1);
    run_playback(bc, oc, ns);
    check("rewin_shows", 32'(ns), 32'd1);
    check("rewin_col", 32'(shown[0]), 32'(4'b0010));
    check("rewin_lvl1", 32'(level), 32'd1);

    // Asynchronous reset in the middle of SHOW_ON
    press(K_YELLOW);
    n = 0;
    while (led == 4'd0 && n < 50) begin
      tick();
      n++;
    end
    check("show_reached", 32'(led), 32'(4'b0010));
    rst = 1'b1;
    #1;
    check("arst_led", 32'(led), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_win", 32'(win), 32'd0);
    check("arst_go", 32'(game_over), 32'd0);
    // rdy already high across reset release must not count as a press
    rdy = 1'b1;
    set_btns(K_POWER);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("stale_rdy_busy", 32'(busy), 32'd0);
    rdy = 1'b0;
    set_btns(5'd0);
    tick();
    color = 2'd2;
    press(K_POWER);
    check("post_rst_busy", 32'(busy), 32'd1);
    run_playback(bc, oc, ns);
    check("post_rst_level", 32'(level), 32'd1);

`ifdef GENIUS_TIMEOUT_EN
    repeat (19) tick();
    check("to_not_yet", 32'(game_over), 32'd0);
    tick();
    check("to_lose", 32'(game_over), 32'd1);
    check("to_led", 32'(led), 32'd0);
`else
    repeat (1000) tick();
    check("no_to_go", 32'(game_over), 32'd0);
    check("no_to_busy", 32'(busy), 32'd0);
    press(K_GREEN);
    check("no_to_accept", 32'(busy), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
